// File: rtl/uart_rx_mini.sv
// uart_rx_mini: 8N1 UART receiver with a small receive FIFO.
//
// Each bit is sampled at its midpoint. A 2-flop synchroniser feeds a
// bit-timing FSM. Good bytes are queued in a circular FIFO that the consumer
// drains through a valid/ready pop port. Framing and overrun errors are
// sticky until clr_err. rts drops while DEPTH-1 or more bytes are queued.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   rx           asynchronous serial line, idle high
//   rx_data[7:0] FIFO head byte, 0 when empty
//   rx_valid     FIFO non-empty
//   rx_ready     consumer pop (pop when rx_valid && rx_ready at posedge)
//   rts          1 while level < DEPTH-1
//   err_frame    sticky: a stop bit was sampled low
//   err_overrun  sticky: a good byte was dropped because the FIFO was full
//   clr_err      one-cycle pulse clears both sticky flags
//   level        FIFO occupancy
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | line idle, waiting for rx_s low
// START   | timing to the middle of the start bit, rejects glitches
// DATA    | sampling 8 data bits, LSB first, one per bit period
// STOP    | sampling the stop bit; push on high, framing error on low
// BRK     | line held low after a framing error; wait for release

module uart_rx_mini #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  output logic [7:0]                 rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic                       rts,
  output logic                       err_frame,
  output logic                       err_overrun,
  input  logic                       clr_err,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LP_HALF_END = 32'((CLKS_PER_BIT >> 1) - 1);
  localparam logic [31:0] LP_BIT_END  = 32'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] LP_FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_RTS_LVL  = (AW+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BRK
  } state_t;

  logic [1:0]  r_sync;
  logic        w_rx_s;

  state_t      r_state, w_nxt_state;
  logic [31:0] r_bcnt, w_nxt_bcnt;
  logic [2:0]  r_idx, w_nxt_idx;
  logic [7:0]  r_shreg, w_nxt_shreg;
  logic        w_push, w_frame_err;

  logic        r_push_pend;
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic [AW:0] w_level;
  logic        w_full, w_pop, w_wr, w_drop;
  logic        r_err_frame, r_err_overrun;

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rx};
  end

  assign w_rx_s = r_sync[1];

  // ---------------------------------------------------------------------
  // Bit-timing FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bcnt  <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_bcnt  <= w_nxt_bcnt;
      r_idx   <= w_nxt_idx;
      r_shreg <= w_nxt_shreg;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_bcnt  = r_bcnt;
    w_nxt_idx   = r_idx;
    w_nxt_shreg = r_shreg;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nxt_bcnt = '0;
        if (!w_rx_s) w_nxt_state = ST_START;
      end
      ST_START: begin
        if (r_bcnt == LP_HALF_END) begin
          w_nxt_bcnt = '0;
          w_nxt_idx  = '0;
          // Line back high at mid start bit: treat as a glitch.
          w_nxt_state = w_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_nxt_bcnt = r_bcnt + 32'd1;
        end
      end
      ST_DATA: begin
        if (r_bcnt == LP_BIT_END) begin
          w_nxt_bcnt  = '0;
          w_nxt_shreg = {w_rx_s, r_shreg[7:1]};
          if (r_idx == 3'd7) w_nxt_state = ST_STOP;
          else               w_nxt_idx   = r_idx + 3'd1;
        end else begin
          w_nxt_bcnt = r_bcnt + 32'd1;
        end
      end
      ST_STOP: begin
        if (r_bcnt == LP_BIT_END) begin
          w_nxt_bcnt = '0;
          if (w_rx_s) begin
            w_push      = 1'b1;
            w_nxt_state = ST_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_nxt_state = ST_BRK;
          end
        end else begin
          w_nxt_bcnt = r_bcnt + 32'd1;
        end
      end
      ST_BRK: begin
        w_nxt_bcnt = '0;
        if (w_rx_s) w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_bcnt  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  // The push is applied one cycle after the stop-bit sample. r_shreg is
  // stable during that cycle because the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) r_push_pend <= 1'b0;
    else     r_push_pend <= w_push;
  end

  assign w_level = r_wr - r_rd;
  assign w_full  = (w_level == LP_FULL);
  assign w_pop   = (w_level != '0) && rx_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_wr    = r_push_pend && (!w_full || w_pop);
  assign w_drop  = r_push_pend && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr[AW-1:0]] <= r_shreg;
  end

  // ---------------------------------------------------------------------
  // Sticky error flags: a new event wins over clr_err
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_frame   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_frame_err)  r_err_frame <= 1'b1;
      else if (clr_err) r_err_frame <= 1'b0;
      if (w_drop)       r_err_overrun <= 1'b1;
      else if (clr_err) r_err_overrun <= 1'b0;
    end
  end

  assign level       = w_level;
  assign rx_valid    = (w_level != '0);
  assign rx_data     = (w_level != '0) ? r_mem[r_rd[AW-1:0]] : 8'h00;
  assign rts         = (w_level < LP_RTS_LVL);
  assign err_frame   = r_err_frame;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_rx_mini.sv
module tb_uart_rx_mini;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int HALF  = CPB / 2;
  localparam int LAT   = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rts;
  logic       err_frame;
  logic       err_overrun;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;

  // Reference model: byte queue plus sticky flags.
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_frm = 1'b0;

  uart_rx_mini #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rts(rts), .err_frame(err_frame), .err_overrun(err_overrun),
    .clr_err(clr_err), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    check({tag, "_level"}, 32'(level), 32'(sz));
    check({tag, "_valid"}, 32'(rx_valid), 32'(sz != 0));
    check({tag, "_data"},  32'(rx_data), (sz != 0) ? 32'(mq[0]) : 32'd0);
    check({tag, "_rts"},   32'(rts), 32'(sz < DEPTH - 1));
    check({tag, "_efrm"},  32'(err_frame), 32'(m_frm));
    check({tag, "_eovr"},  32'(err_overrun), 32'(m_ovr));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: start bit, 8 data bits LSB first, stop bit. rx is left at
  // the stop-bit value so a low stop bit turns into a held break.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(CPB);
    end
    rx = stop_bit;
    step(CPB);
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else                   m_ovr = 1'b1;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    m_ovr = 1'b0;
    m_frm = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] b;

    // Reset
    rst = 1'b1;
    step(3);
    check_model("reset");
    rst = 1'b0;
    step(2);

    // 1: single byte, latency
    n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        do begin
          @(posedge clk);
          n++;
          #1;
        end while (rx_valid !== 1'b1 && n < 400);
      end
    join
    check("t1_latency", 32'(n), 32'(LAT));
    model_rx(8'hA5);
    check_model("t1");
    pop_one();
    check_model("t1_pop");

    // 2: five back-to-back bytes, no consumer
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1);
      model_rx(8'(v));
      check_model($sformatf("t2_byte%0d", v));
    end
    for (int k = 0; k < 4; k++) begin
      check_model($sformatf("t2_pop%0d", k));
      pop_one();
    end
    check_model("t2_empty");
    clear_errors();
    check_model("t2_clr");

    // 3: framing error followed by a held break
    send_frame(8'h3C, 1'b0);
    m_frm = 1'b1;
    check_model("t3_frame");
    step(40 * CPB);
    check_model("t3_brk");
    rx = 1'b1;
    step(2 * CPB);
    check_model("t3_release");
    send_frame(8'h7E, 1'b1);
    model_rx(8'h7E);
    check_model("t3_7e");
    pop_one();
    clear_errors();
    check_model("t3_clr");

    // 4: glitch rejection
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(3 * CPB);
    check_model("t4_glitch");

    // Randomised bytes with random consumer activity
    for (int k = 0; k < 10; k++) begin
      step($urandom_range(0, 4));
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      model_rx(b);
      check_model($sformatf("rnd%0d", k));
      repeat ($urandom_range(0, 2)) pop_one();
      check_model($sformatf("rnd%0d_pop", k));
    end
    while (mq.size() != 0) pop_one();
    clear_errors();
    check_model("rnd_drain");

    // 5: push and pop in the same cycle while full
    for (int v = 0; v < 4; v++) begin
      send_frame(8'hA1 + 8'(v), 1'b1);
      model_rx(8'hA1 + 8'(v));
    end
    check_model("t5_full");
    step(1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (LAT) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'h99);
    check_model("t5_simul");
    for (int k = 0; k < 3; k++) begin
      pop_one();
      check_model($sformatf("t5_drain%0d", k));
    end
    check("t5_last", 32'(rx_data), 32'h99);

    // 6: reset during data bit 4 of 0xF0
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (82) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
        check_model("t6_rst");
      end
    join
    step(2 * CPB);
    check_model("t6_idle");
    send_frame(8'h55, 1'b1);
    model_rx(8'h55);
    check_model("t6_55");
    pop_one();
    check_model("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_mini.md
Name: uart_rx_mini

Overview:
8N1 UART receiver that pairs with the existing mini UART transmitter and shares its bit timing. A 2-flop synchroniser feeds a bit-timing FSM that mid-bit samples the start bit, 8 data bits (LSB first) and the stop bit. Good bytes go into a small FIFO with a valid/ready pop port. Framing and overrun errors are reported as sticky flags, and an RTS level provides flow control.

Parameters:
CLKS_PER_BIT, `SERIAL_WCNT (define.vh), clk cycles per bit; must be >= 4; HALF = CLKS_PER_BIT>>1.
DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx  in  1  serial line, asynchronous, idle high
rx_data  out  8  FIFO head byte; 0 when empty
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer pop; a pop occurs when rx_valid && rx_ready at posedge
rts  out  1  1 when FIFO level < DEPTH-1 (combinational from level)
err_frame  out  1  sticky: a stop bit was sampled 0
err_overrun  out  1  sticky: a good byte was dropped because the FIFO was full
clr_err  in  1  one-cycle pulse clears both sticky flags
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, synchronous, any state: sync flops <= 1; FSM <= IDLE; counters 0; FIFO empty; errors 0.
- Outputs during and after reset: rx_valid=0, rx_data=0, level=0, rts=1, err_*=0.
- A mid-frame reset drops the partial byte; no flag is set.
- Synchroniser: rx_s is rx delayed 2 cycles. All FSM decisions use rx_s only.
- Bit counter bcnt (32 bit) and bit index idx (3 bit).
- FSM IDLE: bcnt=0. When rx_s==0, go to START.
- FSM START: bcnt++ each cycle. When bcnt==HALF-1, sample rx_s:
  - rx_s=1: glitch; go to IDLE, nothing is recorded.
  - rx_s=0: go to DATA with bcnt=0, idx=0.
- FSM DATA: bcnt++. When bcnt==CLKS_PER_BIT-1:
  - shift rx_s into shreg MSB (LSB-first reception); bcnt=0.
  - if idx==7, go to STOP; else idx++.
- FSM STOP: bcnt++. When bcnt==CLKS_PER_BIT-1, sample rx_s:
  - rx_s=1: push shreg; go to IDLE.
  - rx_s=0: set err_frame, discard the byte, go to BRK.
- FSM BRK: stay until rx_s==1, then go to IDLE. This stops a held-low break from retriggering.
- Latency: rx_valid rises exactly 2 + HALF + 9*CLKS_PER_BIT + 1 cycles after the first posedge that samples rx low, when the FIFO was empty.
  - Cycle breakdown: 2 sync, HALF start-bit check, 8 data bits + 1 stop bit at CLKS_PER_BIT each, 1 FIFO write.
- FIFO: circular buffer; wr/rd pointers have one extra wrap bit; full when level==DEPTH.
  - rx_data is driven from the read pointer; it shows 8'h00 when empty.
- Push and pop in the same cycle:
  - both are performed; level unchanged.
  - if the FIFO was full, the push is accepted and no overrun is flagged.
- Push while full with no pop: byte dropped, err_overrun <= 1, FIFO unchanged.
- Pop while empty: ignored.
- Sticky flags: clr_err clears both. If clr_err and a new error event occur in the same cycle, the flag ends 1 (set wins).
- rts tracks level combinationally; it deasserts once DEPTH-1 bytes are queued, leaving one byte of margin.

Test Plan:
1. Single byte, CLKS_PER_BIT=16, DEPTH=4: send 0xA5 with rx_ready=0 -> rx_valid rises 155 cycles after rx low is first sampled; rx_data=0xA5; level=1; no errors.
2. Five back-to-back bytes 0x01..0x05, rx_ready=0:
   - rts falls after byte 3.
   - level=4 after byte 4.
   - byte 5 dropped, err_overrun=1.
   - popping returns 01,02,03,04 in order.
   - clr_err pulse -> err_overrun=0.
3. Framing error: send 0x3C with stop bit 0, then hold rx low for 40 bit times -> err_frame=1; no push; FSM stays in BRK with no retrigger. Then release rx and send 0x7E -> 0x7E is received correctly.
4. Glitch rejection: rx low for 3 cycles, then high -> FSM returns to IDLE; level=0; no flags.
5. Simultaneous push/pop: FIFO full, rx_ready held 1 across the stop-bit sample of byte 0x99 -> level stays 4; no overrun; 0x99 is last out.
6. Reset mid-frame: assert rst during DATA bit 4 of 0xF0 -> next cycle: level=0, rx_valid=0, flags 0, FSM IDLE. Then send 0x55 -> received correctly.
